shape_rasterizer: RTL and testbench
===================================

SHAPE_RASTERIZER -- requirements
Module: shape_rasterizer

Interface
REQ-001 SHALL have parameter X_BITS, default 7: pixel x-coordinate width; image width 2^X_BITS.
REQ-002 SHALL have parameter Y_BITS, default 7: pixel y-coordinate width; image height 2^Y_BITS.
REQ-003 SHALL have parameter COLOUR_BYTES, default 3: bytes per colour, range 1..4.
REQ-004 SHALL have parameter ADDR_W, default 24: byte-address width.
REQ-005 SHALL have parameter FB_BASE, default 24'h800000: framebuffer base byte address.
REQ-006 SHALL have parameter BG_COLOUR, default 0: colour written where no shape covers a pixel.
REQ-007 Ports SHALL be:
  clk  in  1  clock; one clock; reset is synchronous and active-high
  rst  in  1  synchronous active-high reset
  start  in  1  single-cycle pulse; begins one frame render
  busy  out  1  high from the cycle after an accepted start until done
  done  out  1  single-cycle pulse after the final framebuffer byte is acknowledged
  rd_req  out  1  read request, held until rd_valid
  rd_addr  out  ADDR_W  read byte address, stable while rd_req is high
  rd_valid  in  1  read data valid; completes the request
  rd_data  in  8  read data byte
  wr_req  out  1  write request, held until wr_ack
  wr_addr  out  ADDR_W  write byte address, stable while wr_req is high
  wr_data  out  8  write data byte, stable while wr_req is high
  wr_ack  in  1  write accepted; completes the request

Function
REQ-008 Scene memory layout SHALL be: byte 0 = N (shape count, 0..255); shape s record at 1 + s*(4+COLOUR_BYTES): xmin, xmax, ymin, ymax, then colour bytes LSB first.
REQ-009 States SHALL be IDLE, RD_COUNT, RD_BBOX, TEST, RD_COLOUR, WRITE, NEXT_PIXEL, DONE.
REQ-010 IDLE->RD_COUNT on start; start while busy SHALL be ignored.
REQ-011 At most one read and one write outstanding; a read or write SHALL complete in the cycle rd_valid or wr_ack is sampled high with its request high; the next request SHALL assert no earlier than the following cycle.
REQ-012 Pixels SHALL be visited in raster order, x fastest; pixel index p = y*2^X_BITS + x.
REQ-013 For each pixel: colour accumulator = BG_COLOUR; shapes 0..N-1 SHALL be scanned in order: RD_BBOX reads 4 bytes, then TEST.
REQ-014 Containment SHALL be inclusive: xmin<=x<=xmax and ymin<=y<=ymax, compared zero-extended to 8 bits; coordinates above the image range never match; xmin>xmax or ymin>ymax never matches.
REQ-015 On a match, RD_COLOUR SHALL read the colour bytes and overwrite the accumulator (painter's order: the last matching shape wins); on a miss, the colour bytes SHALL NOT be read, and the next record address SHALL be computed by stride.
REQ-016 After the last shape (or immediately when N=0), WRITE SHALL issue COLOUR_BYTES writes, LSB first, to FB_BASE + p*COLOUR_BYTES + k.
REQ-017 N SHALL be read once per frame; the bounding boxes SHALL be re-read for every pixel, with no caching.
REQ-018 After pixel 2^(X_BITS+Y_BITS)-1, DONE SHALL pulse done for one cycle, deassert busy in the same cycle, and return to IDLE; the pixel counter SHALL NOT wrap into a second frame.
REQ-019 Address arithmetic SHALL be ADDR_W bits, wrapping modulo 2^ADDR_W.
REQ-020 rd_valid without rd_req, and wr_ack without wr_req, SHALL be ignored.

Reset
REQ-021 rst SHALL force IDLE; busy, done, rd_req and wr_req = 0; rd_addr, wr_addr and wr_data = 0; counters and accumulator cleared.
REQ-022 rst mid-frame SHALL abandon the outstanding request with no further write; the next start SHALL render a full frame.

Structure
REQ-023 Package shape_raster_pkg SHALL hold the state enum, BBOX_BYTES=4 and default FB_BASE.
REQ-024 Sub-module raster_byte_reader SHALL perform the request/hold/capture of 1..4 consecutive bytes into a shift register.

Verification
REQ-025 X_BITS=Y_BITS=2, N=0, start -> 16*3 writes of 0 to 0x800000..0x80002F, then done; rd_addr 0 read once only.
REQ-026 N=1, box (1,2,1,1), colour 0x112233 -> pixels 5,6 get 33,22,11 at 0x80000F..0x800014; all others 0; colour read only for pixels 5,6.
REQ-027 N=2, overlapping boxes (0,3,0,3) red 0x0000FF and (1,1,1,1) 0x00FF00 -> pixel 5 = FF00 colour, others 0x0000FF.
REQ-028 Random rd_valid/wr_ack delays 0..7 cycles -> same write stream as zero-delay run; addresses and data stable while requests are high.
REQ-029 rst asserted during a pixel-9 write -> wr_req low next cycle; restart -> complete frame from pixel 0, done once.
REQ-030 start pulsed while busy and box xmin=5>xmax=2 -> second start ignored; box never matches.

Source files
------------

// File: rtl/shape_raster_pkg.sv
// Shared definitions for the shape rasterizer slice.
//   raster_state_e  : top-level FSM states
//   BBOX_BYTES      : bytes per bounding-box record header (xmin, xmax, ymin, ymax)
//   DEFAULT_FB_BASE : default framebuffer base byte address
//   byte_sel()      : pick byte k (LSB = 0) out of a 32-bit word
package shape_raster_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_COUNT,
    RD_BBOX,
    TEST,
    RD_COLOUR,
    WRITE,
    NEXT_PIXEL,
    DONE
  } raster_state_e;

  localparam int unsigned BBOX_BYTES      = 4;
  localparam logic [23:0] DEFAULT_FB_BASE = 24'h800000;

  function automatic logic [7:0] byte_sel(input logic [31:0] v, input logic [1:0] k);
    logic [31:0] t;
    t = v >> {k, 3'b000};
    return t[7:0];
  endfunction

endpackage

// File: rtl/raster_byte_reader.sv
// Reads 1..4 consecutive bytes over a single-outstanding request/valid port.
//   go_i      : pulse (while idle) to start a burst at addr_i of nbytes_i bytes
//   rd_req_o  : held high until rd_valid_i; rd_addr_o stable meanwhile
//   done_o    : one-cycle pulse after the last byte has been captured
//   data_o    : captured bytes, first byte in [7:0]; held until the next go_i
module raster_byte_reader
  import shape_raster_pkg::*;
#(
  parameter int unsigned ADDR_W = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              go_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [2:0]        nbytes_i,
  output logic              rd_req_o,
  output logic [ADDR_W-1:0] rd_addr_o,
  input  logic              rd_valid_i,
  input  logic [7:0]        rd_data_i,
  output logic              done_o,
  output logic [31:0]       data_o
);

  logic              req_q, req_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [2:0]        n_q, n_d;
  logic [31:0]       shreg_q, shreg_d;
  logic              done_q, done_d;

  always_comb begin
    req_d   = req_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    n_d     = n_q;
    shreg_d = shreg_q;
    done_d  = 1'b0;
    if (req_q) begin
      if (rd_valid_i) begin
        // Bytes enter at the top and shift down, so the first byte ends lowest.
        shreg_d = {rd_data_i, shreg_q[31:8]};
        addr_d  = addr_q + ADDR_W'(1);
        cnt_d   = cnt_q - 3'd1;
        if (cnt_q == 3'd1) begin
          req_d  = 1'b0;
          done_d = 1'b1;
        end
      end
    end else if (go_i) begin
      req_d   = 1'b1;
      addr_d  = addr_i;
      cnt_d   = nbytes_i;
      n_d     = nbytes_i;
      shreg_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      req_q   <= 1'b0;
      addr_q  <= '0;
      cnt_q   <= '0;
      n_q     <= '0;
      shreg_q <= '0;
      done_q  <= 1'b0;
    end else begin
      req_q   <= req_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      n_q     <= n_d;
      shreg_q <= shreg_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    case (n_q)
      3'd1:    data_o = {24'b0, shreg_q[31:24]};
      3'd2:    data_o = {16'b0, shreg_q[31:16]};
      3'd3:    data_o = {8'b0, shreg_q[31:8]};
      default: data_o = shreg_q;
    endcase
  end

  assign rd_req_o  = req_q;
  assign rd_addr_o = addr_q;
  assign done_o    = done_q;

endmodule

// File: rtl/shape_rasterizer.sv
// Renders one frame of axis-aligned coloured boxes into a byte framebuffer.
// Scene memory: byte 0 = shape count N, then per shape xmin, xmax, ymin, ymax,
// colour (LSB first). Every pixel rescans all shapes; last matching shape wins.
//   start         : pulse to begin a frame (ignored while busy)
//   busy / done   : frame in progress / one-cycle completion pulse
//   rd_*          : byte read port (req held until valid)
//   wr_*          : byte write port (req held until ack)
module shape_rasterizer
  import shape_raster_pkg::*;
#(
  parameter int unsigned X_BITS       = 7,
  parameter int unsigned Y_BITS       = 7,
  parameter int unsigned COLOUR_BYTES = 3,
  parameter int unsigned ADDR_W       = 24,
  parameter logic [ADDR_W-1:0] FB_BASE = ADDR_W'(DEFAULT_FB_BASE),
  parameter logic [8*COLOUR_BYTES-1:0] BG_COLOUR = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              rd_req,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_valid,
  input  logic [7:0]        rd_data,
  output logic              wr_req,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  input  logic              wr_ack
);

  localparam int unsigned       CW     = 8 * COLOUR_BYTES;
  localparam int unsigned       P_BITS = X_BITS + Y_BITS;
  localparam logic [ADDR_W-1:0] STRIDE = ADDR_W'(BBOX_BYTES + COLOUR_BYTES);
  localparam logic [2:0]        LAST_K = 3'(COLOUR_BYTES - 1);

  raster_state_e     state_q, state_d;
  logic [P_BITS-1:0] p_q, p_d;
  logic [7:0]        n_q, n_d;
  logic [7:0]        shape_q, shape_d;
  logic [ADDR_W-1:0] rec_q, rec_d;
  logic [ADDR_W-1:0] fb_q, fb_d;
  logic [CW-1:0]     acc_q, acc_d;
  logic [2:0]        k_q, k_d;
  logic              wr_req_q, wr_req_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]        wr_data_q, wr_data_d;

  logic              rd_go;
  logic [ADDR_W-1:0] rd_go_addr;
  logic [2:0]        rd_go_n;
  logic              rd_done;
  logic [31:0]       rd_word;

  logic [31:0] x32, y32;
  logic        hit;
  logic        advance;
  logic [31:0] acc32;

  raster_byte_reader #(
    .ADDR_W(ADDR_W)
  ) u_reader (
    .clk        (clk),
    .rst        (rst),
    .go_i       (rd_go),
    .addr_i     (rd_go_addr),
    .nbytes_i   (rd_go_n),
    .rd_req_o   (rd_req),
    .rd_addr_o  (rd_addr),
    .rd_valid_i (rd_valid),
    .rd_data_i  (rd_data),
    .done_o     (rd_done),
    .data_o     (rd_word)
  );

  // Inclusive containment against the bbox just read (xmin, xmax, ymin, ymax).
  always_comb begin
    x32 = 32'(p_q[X_BITS-1:0]);
    y32 = 32'(p_q[P_BITS-1:X_BITS]);
    hit = (32'(rd_word[7:0])   <= x32) && (x32 <= 32'(rd_word[15:8])) &&
          (32'(rd_word[23:16]) <= y32) && (y32 <= 32'(rd_word[31:24]));
  end

  assign acc32 = 32'(acc_q);

  always_comb begin
    state_d    = state_q;
    p_d        = p_q;
    n_d        = n_q;
    shape_d    = shape_q;
    rec_d      = rec_q;
    fb_d       = fb_q;
    acc_d      = acc_q;
    k_d        = k_q;
    wr_req_d   = wr_req_q;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    rd_go      = 1'b0;
    rd_go_addr = '0;
    rd_go_n    = 3'd1;
    advance    = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          p_d        = '0;
          shape_d    = '0;
          rec_d      = ADDR_W'(1);
          fb_d       = FB_BASE;
          acc_d      = BG_COLOUR;
          k_d        = '0;
          rd_go      = 1'b1;
          rd_go_addr = '0;
          rd_go_n    = 3'd1;
          state_d    = RD_COUNT;
        end
      end

      RD_COUNT: begin
        if (rd_done) begin
          n_d = rd_word[7:0];
          if (rd_word[7:0] == 8'd0) begin
            state_d = WRITE;
          end else begin
            rd_go      = 1'b1;
            rd_go_addr = rec_q;
            rd_go_n    = 3'd4;
            state_d    = RD_BBOX;
          end
        end
      end

      RD_BBOX: begin
        if (rd_done) state_d = TEST;
      end

      TEST: begin
        if (hit) begin
          rd_go      = 1'b1;
          rd_go_addr = rec_q + ADDR_W'(BBOX_BYTES);
          rd_go_n    = 3'(COLOUR_BYTES);
          state_d    = RD_COLOUR;
        end else begin
          advance = 1'b1;
        end
      end

      RD_COLOUR: begin
        if (rd_done) begin
          acc_d   = rd_word[CW-1:0];
          advance = 1'b1;
        end
      end

      WRITE: begin
        if (!wr_req_q) begin
          wr_req_d  = 1'b1;
          wr_addr_d = fb_q;
          wr_data_d = byte_sel(acc32, k_q[1:0]);
        end else if (wr_ack) begin
          fb_d = fb_q + ADDR_W'(1);
          if (k_q == LAST_K) begin
            wr_req_d = 1'b0;
            k_d      = '0;
            state_d  = NEXT_PIXEL;
          end else begin
            k_d       = k_q + 3'd1;
            wr_addr_d = fb_q + ADDR_W'(1);
            wr_data_d = byte_sel(acc32, k_q[1:0] + 2'd1);
          end
        end
      end

      NEXT_PIXEL: begin
        if (&p_q) begin
          state_d = DONE;
        end else begin
          p_d     = p_q + P_BITS'(1);
          shape_d = '0;
          rec_d   = ADDR_W'(1);
          acc_d   = BG_COLOUR;
          if (n_q == 8'd0) begin
            state_d = WRITE;
          end else begin
            rd_go      = 1'b1;
            rd_go_addr = ADDR_W'(1);
            rd_go_n    = 3'd4;
            state_d    = RD_BBOX;
          end
        end
      end

      DONE: state_d = IDLE;

      default: state_d = IDLE;
    endcase

    // Shared exit from TEST (miss) and RD_COLOUR: step to the next record by stride.
    if (advance) begin
      shape_d = shape_q + 8'd1;
      rec_d   = rec_q + STRIDE;
      if (shape_q + 8'd1 == n_q) begin
        state_d = WRITE;
      end else begin
        rd_go      = 1'b1;
        rd_go_addr = rec_q + STRIDE;
        rd_go_n    = 3'd4;
        state_d    = RD_BBOX;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      p_q       <= '0;
      n_q       <= '0;
      shape_q   <= '0;
      rec_q     <= '0;
      fb_q      <= '0;
      acc_q     <= '0;
      k_q       <= '0;
      wr_req_q  <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      p_q       <= p_d;
      n_q       <= n_d;
      shape_q   <= shape_d;
      rec_q     <= rec_d;
      fb_q      <= fb_d;
      acc_q     <= acc_d;
      k_q       <= k_d;
      wr_req_q  <= wr_req_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign busy    = (state_q != IDLE) && (state_q != DONE);
  assign done    = (state_q == DONE);
  assign wr_req  = wr_req_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;

endmodule

// File: tb/tb_shape_rasterizer.sv
module tb_shape_rasterizer;

  logic        clk = 1'b0;
  logic        rst, start, busy, done;
  logic        rd_req, rd_valid, wr_req, wr_ack;
  logic [23:0] rd_addr, wr_addr;
  logic [7:0]  rd_data, wr_data;

  int checks = 0;
  int errors = 0;

  logic [7:0]  scene [0:255];
  bit          rand_en = 1'b0;
  int          rd_total = 0, rd0_cnt = 0, colour_cnt = 0;
  int          rd_unstable = 0, wr_unstable = 0, done_cnt = 0;
  logic [23:0] wa_log[$];
  logic [7:0]  wd_log[$];

  always #5 clk = ~clk;

  shape_rasterizer #(
    .X_BITS(2),
    .Y_BITS(2)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_data(rd_data),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack)
  );

  // Scene memory responder: optional 0..7 cycle latency, checks address hold.
  initial begin
    int cnt;
    logic [23:0] hold;
    cnt = -1; hold = '0; rd_valid = 1'b0; rd_data = '0;
    forever begin
      @(posedge clk); #1;
      rd_valid = 1'b0;
      if (rd_req !== 1'b1 || rst === 1'b1) cnt = -1;
      else begin
        if (cnt < 0) begin
          cnt = rand_en ? int'($urandom_range(0, 7)) : 0;
          hold = rd_addr;
        end else if (rd_addr !== hold) rd_unstable++;
        if (cnt == 0) begin
          rd_valid = 1'b1;
          rd_data = scene[rd_addr[7:0]];
          rd_total++;
          if (rd_addr == 24'd0) rd0_cnt++;
          else if (((rd_addr - 24'd1) % 24'd7) >= 24'd4) colour_cnt++;
          cnt = -1;
        end else cnt--;
      end
    end
  end

  // Framebuffer responder: logs each accepted byte, checks address/data hold.
  initial begin
    int cnt;
    logic [23:0] ha;
    logic [7:0]  hd;
    cnt = -1; ha = '0; hd = '0; wr_ack = 1'b0;
    forever begin
      @(posedge clk); #1;
      wr_ack = 1'b0;
      if (wr_req !== 1'b1 || rst === 1'b1) cnt = -1;
      else begin
        if (cnt < 0) begin
          cnt = rand_en ? int'($urandom_range(0, 7)) : 0;
          ha = wr_addr; hd = wr_data;
        end else if (wr_addr !== ha || wr_data !== hd) wr_unstable++;
        if (cnt == 0) begin
          wr_ack = 1'b1;
          wa_log.push_back(wr_addr);
          wd_log.push_back(wr_data);
          cnt = -1;
        end else cnt--;
      end
    end
  end

  initial forever begin
    @(posedge clk); #1;
    if (done === 1'b1) done_cnt++;
  end

  // Expected framebuffer byte idx (pixel idx/3, byte idx%3) per scene.
  function automatic logic [7:0] exp_byte(input int scn, input int idx);
    int p, k;
    p = idx / 3; k = idx % 3;
    case (scn)
      1: begin
        if (p == 5 || p == 6) return (k == 0) ? 8'h33 : (k == 1) ? 8'h22 : 8'h11;
        return 8'h00;
      end
      2: begin
        if (p == 5) return (k == 1) ? 8'hFF : 8'h00;
        return (k == 0) ? 8'hFF : 8'h00;
      end
      default: return 8'h00;
    endcase
  endfunction

  task automatic run_frame(output bit ok, output logic busy_after, output logic busy_at_done);
    ok = 1'b0; busy_at_done = 1'bx;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    busy_after = busy;
    for (int i = 0; i < 20000; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) begin ok = 1'b1; busy_at_done = busy; break; end
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0;
    repeat (3) @(posedge clk); #1;
    checks++;
    if ({busy, done, rd_req, wr_req} !== 4'b0) begin
      errors++; $display("FAIL reset_ctrl: got %b, expected 0000", {busy, done, rd_req, wr_req});
    end
    checks++;
    if (rd_addr !== 24'h0) begin errors++; $display("FAIL reset_rd_addr: got %h, expected 000000", rd_addr); end
    checks++;
    if (wr_addr !== 24'h0 || wr_data !== 8'h0) begin
      errors++; $display("FAIL reset_wr: got addr %h data %h, expected 000000 00", wr_addr, wr_data);
    end
    @(negedge clk); rst = 1'b0;
    repeat (5) @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || rd_req !== 1'b0) begin
      errors++; $display("FAIL idle_hold: got busy %b rd_req %b, expected 0 0", busy, rd_req);
    end
  endtask

  task automatic test_empty_scene();
    bit ok; logic ba, bd; int base, r0, rt, dc;
    scene[0] = 8'd0;
    base = wa_log.size(); r0 = rd0_cnt; rt = rd_total; dc = done_cnt;
    run_frame(ok, ba, bd);
    checks++; if (!ok) begin errors++; $display("FAIL empty_done: got timeout, expected done"); end
    checks++; if (ba !== 1'b1) begin errors++; $display("FAIL empty_busy: got %b, expected 1", ba); end
    checks++; if (bd !== 1'b0) begin errors++; $display("FAIL empty_busy_at_done: got %b, expected 0", bd); end
    checks++; if (wa_log.size() - base != 48) begin errors++; $display("FAIL empty_count: got %0d, expected 48", wa_log.size() - base); end
    for (int i = 0; i < 48 && base + i < wa_log.size(); i++) begin
      checks++;
      if (wa_log[base+i] !== 24'h800000 + 24'(i) || wd_log[base+i] !== exp_byte(0, i)) begin
        errors++; $display("FAIL empty_write %0d: got %h/%h, expected %h/%h", i, wa_log[base+i], wd_log[base+i], 24'h800000 + 24'(i), exp_byte(0, i));
      end
    end
    checks++; if (rd0_cnt - r0 != 1 || rd_total - rt != 1) begin errors++; $display("FAIL empty_reads: got %0d/%0d, expected 1/1", rd0_cnt - r0, rd_total - rt); end
    checks++; if (done_cnt - dc != 1) begin errors++; $display("FAIL empty_done_cnt: got %0d, expected 1", done_cnt - dc); end
  endtask

  task automatic test_single_box();
    bit ok; logic ba, bd; int base, cc, rt;
    scene[0] = 8'd1;
    scene[1] = 8'd1; scene[2] = 8'd2; scene[3] = 8'd1; scene[4] = 8'd1;
    scene[5] = 8'h33; scene[6] = 8'h22; scene[7] = 8'h11;
    base = wa_log.size(); cc = colour_cnt; rt = rd_total;
    run_frame(ok, ba, bd);
    checks++; if (!ok) begin errors++; $display("FAIL single_done: got timeout, expected done"); end
    checks++; if (wa_log.size() - base != 48) begin errors++; $display("FAIL single_count: got %0d, expected 48", wa_log.size() - base); end
    for (int i = 0; i < 48 && base + i < wa_log.size(); i++) begin
      checks++;
      if (wa_log[base+i] !== 24'h800000 + 24'(i) || wd_log[base+i] !== exp_byte(1, i)) begin
        errors++; $display("FAIL single_write %0d: got %h/%h, expected %h/%h", i, wa_log[base+i], wd_log[base+i], 24'h800000 + 24'(i), exp_byte(1, i));
      end
    end
    checks++; if (colour_cnt - cc != 6) begin errors++; $display("FAIL single_colour_reads: got %0d, expected 6", colour_cnt - cc); end
    checks++; if (rd_total - rt != 71) begin errors++; $display("FAIL single_reads: got %0d, expected 71", rd_total - rt); end
  endtask

  task automatic load_overlap();
    scene[0] = 8'd2;
    scene[1] = 8'd0; scene[2] = 8'd3; scene[3] = 8'd0; scene[4] = 8'd3;
    scene[5] = 8'hFF; scene[6] = 8'h00; scene[7] = 8'h00;
    scene[8] = 8'd1; scene[9] = 8'd1; scene[10] = 8'd1; scene[11] = 8'd1;
    scene[12] = 8'h00; scene[13] = 8'hFF; scene[14] = 8'h00;
  endtask

  task automatic test_overlap();
    bit ok; logic ba, bd; int base, cc, rt;
    load_overlap();
    base = wa_log.size(); cc = colour_cnt; rt = rd_total;
    run_frame(ok, ba, bd);
    checks++; if (!ok) begin errors++; $display("FAIL overlap_done: got timeout, expected done"); end
    checks++; if (wa_log.size() - base != 48) begin errors++; $display("FAIL overlap_count: got %0d, expected 48", wa_log.size() - base); end
    for (int i = 0; i < 48 && base + i < wa_log.size(); i++) begin
      checks++;
      if (wa_log[base+i] !== 24'h800000 + 24'(i) || wd_log[base+i] !== exp_byte(2, i)) begin
        errors++; $display("FAIL overlap_write %0d: got %h/%h, expected %h/%h", i, wa_log[base+i], wd_log[base+i], 24'h800000 + 24'(i), exp_byte(2, i));
      end
    end
    checks++; if (colour_cnt - cc != 51) begin errors++; $display("FAIL overlap_colour_reads: got %0d, expected 51", colour_cnt - cc); end
    checks++; if (rd_total - rt != 180) begin errors++; $display("FAIL overlap_reads: got %0d, expected 180", rd_total - rt); end
  endtask

  task automatic test_random_delays();
    bit ok; logic ba, bd; int base, ru, wu;
    load_overlap();
    rand_en = 1'b1;
    base = wa_log.size(); ru = rd_unstable; wu = wr_unstable;
    run_frame(ok, ba, bd);
    rand_en = 1'b0;
    checks++; if (!ok) begin errors++; $display("FAIL random_done: got timeout, expected done"); end
    checks++; if (wa_log.size() - base != 48) begin errors++; $display("FAIL random_count: got %0d, expected 48", wa_log.size() - base); end
    for (int i = 0; i < 48 && base + i < wa_log.size(); i++) begin
      checks++;
      if (wa_log[base+i] !== 24'h800000 + 24'(i) || wd_log[base+i] !== exp_byte(2, i)) begin
        errors++; $display("FAIL random_write %0d: got %h/%h, expected %h/%h", i, wa_log[base+i], wd_log[base+i], 24'h800000 + 24'(i), exp_byte(2, i));
      end
    end
    checks++; if (rd_unstable - ru != 0) begin errors++; $display("FAIL random_rd_hold: got %0d changes, expected 0", rd_unstable - ru); end
    checks++; if (wr_unstable - wu != 0) begin errors++; $display("FAIL random_wr_hold: got %0d changes, expected 0", wr_unstable - wu); end
  endtask

  task automatic test_reset_mid_frame();
    bit ok, found; logic ba, bd; int base, dc, snap;
    scene[0] = 8'd0;
    dc = done_cnt; found = 1'b0;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk); #1;
      if (wr_req === 1'b1 && wr_addr === 24'h80001B) begin found = 1'b1; break; end
    end
    checks++; if (!found) begin errors++; $display("FAIL midrst_reach_px9: got timeout, expected pixel 9 write"); end
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (wr_req !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL midrst_abort: got wr_req %b busy %b, expected 0 0", wr_req, busy);
    end
    snap = wa_log.size();
    @(negedge clk); @(negedge clk); rst = 1'b0;
    repeat (5) @(posedge clk); #1;
    checks++; if (wa_log.size() != snap || wr_req !== 1'b0) begin errors++; $display("FAIL midrst_no_write: got %0d writes, expected 0", wa_log.size() - snap); end
    base = wa_log.size();
    run_frame(ok, ba, bd);
    checks++; if (!ok) begin errors++; $display("FAIL midrst_done: got timeout, expected done"); end
    checks++; if (wa_log.size() - base != 48) begin errors++; $display("FAIL midrst_count: got %0d, expected 48", wa_log.size() - base); end
    for (int i = 0; i < 48 && base + i < wa_log.size(); i++) begin
      checks++;
      if (wa_log[base+i] !== 24'h800000 + 24'(i) || wd_log[base+i] !== 8'h00) begin
        errors++; $display("FAIL midrst_write %0d: got %h/%h, expected %h/00", i, wa_log[base+i], wd_log[base+i], 24'h800000 + 24'(i));
      end
    end
    checks++; if (done_cnt - dc != 1) begin errors++; $display("FAIL midrst_done_cnt: got %0d, expected 1", done_cnt - dc); end
  endtask

  task automatic test_start_while_busy();
    bit ok; int base, cc, r0, dc;
    scene[0] = 8'd1;
    scene[1] = 8'd5; scene[2] = 8'd2; scene[3] = 8'd0; scene[4] = 8'd3;
    scene[5] = 8'hAA; scene[6] = 8'hBB; scene[7] = 8'hCC;
    base = wa_log.size(); cc = colour_cnt; r0 = rd0_cnt; dc = done_cnt; ok = 1'b0;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (20) @(posedge clk);
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL busy_start_busy: got %b, expected 1", busy); end
    for (int i = 0; i < 20000; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) begin ok = 1'b1; break; end
    end
    repeat (10) @(negedge clk);
    checks++; if (!ok) begin errors++; $display("FAIL busy_done: got timeout, expected done"); end
    checks++; if (wa_log.size() - base != 48) begin errors++; $display("FAIL busy_count: got %0d, expected 48", wa_log.size() - base); end
    for (int i = 0; i < 48 && base + i < wa_log.size(); i++) begin
      checks++;
      if (wa_log[base+i] !== 24'h800000 + 24'(i) || wd_log[base+i] !== 8'h00) begin
        errors++; $display("FAIL busy_write %0d: got %h/%h, expected %h/00", i, wa_log[base+i], wd_log[base+i], 24'h800000 + 24'(i));
      end
    end
    checks++; if (colour_cnt - cc != 0) begin errors++; $display("FAIL busy_colour_reads: got %0d, expected 0", colour_cnt - cc); end
    checks++; if (rd0_cnt - r0 != 1) begin errors++; $display("FAIL busy_count_reads: got %0d, expected 1", rd0_cnt - r0); end
    checks++; if (done_cnt - dc != 1) begin errors++; $display("FAIL busy_done_cnt: got %0d, expected 1", done_cnt - dc); end
    checks++; if (busy !== 1'b0 || rd_req !== 1'b0) begin errors++; $display("FAIL busy_idle_after: got busy %b rd_req %b, expected 0 0", busy, rd_req); end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0;
    for (int i = 0; i < 256; i++) scene[i] = 8'h00;
    test_reset();
    test_empty_scene();
    test_single_box();
    test_overlap();
    test_random_delays();
    test_reset_mid_frame();
    test_start_while_busy();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
